// File: rtl/ram_arbiter.sv
// Round-robin arbiter for one shared RAM port. It grants one channel at a time,
// holds the grant until done, the request drops, or the hold limit is reached,
// and then inserts a one-cycle turnaround before the next arbitration.
module ram_arbiter #(
    parameter int N_CH     = 19,
    parameter int HOLD_MAX = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic            done,
    output logic [7:0]      channel,
    output logic [N_CH-1:0] grant,
    output logic            busy,
    output logic            timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [7:0]  NO_CH    = 8'hFF;
    localparam logic [15:0] HOLD_LIM = 16'(HOLD_MAX - 1);
    localparam logic [15:0] HOLD_SAT = 16'(HOLD_MAX);

    logic [1:0]      state_q,   state_d;
    logic [N_CH-1:0] grant_q,   grant_d;
    logic [7:0]      channel_q, channel_d;
    logic            busy_q,    busy_d;
    logic            timeout_q, timeout_d;
    logic [15:0]     hold_q,    hold_d;
    logic [7:0]      last_q,    last_d;

    logic            hi_found, lo_found;
    logic [7:0]      hi_idx, lo_idx, win_idx;
    logic [N_CH-1:0] win_oh;
    logic            hold_at_lim, owner_req, grant_end;

    // Round-robin pick: first requester above last_granted, else first requester from 0
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        win_oh   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (req[i] && (i > int'(last_q)) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = 8'(i);
            end
            if (req[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = 8'(i);
            end
        end
        win_idx = hi_found ? hi_idx : lo_idx;
        for (int i = 0; i < N_CH; i++) begin
            win_oh[i] = (8'(i) == win_idx);
        end
    end

    // Grant termination conditions; the owner's request is read through the one-hot grant
    assign hold_at_lim = (hold_q == HOLD_LIM);
    assign owner_req   = |(req & grant_q);
    assign grant_end   = done | ~owner_req | hold_at_lim;

    // Next-state logic for the IDLE -> GRANT -> RELEASE cycle
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        channel_d = channel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        hold_d    = hold_q;
        last_d    = last_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d   = S_GRANT;
                    grant_d   = win_oh;
                    channel_d = win_idx;
                    busy_d    = 1'b1;
                    hold_d    = '0;
                    last_d    = win_idx;
                end
            end
            S_GRANT: begin
                if (grant_end) begin
                    state_d   = S_RELEASE;
                    grant_d   = '0;
                    channel_d = NO_CH;
                    busy_d    = 1'b0;
                    // A done on the limit cycle counts as a normal completion
                    timeout_d = hold_at_lim & ~done;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 16'd1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                grant_d   = '0;
                channel_d = NO_CH;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset to the idle, channel-0-first condition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            channel_q <= NO_CH;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= 8'(N_CH - 1);
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            channel_q <= channel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    assign channel = channel_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, channel sweep, async reset
// mid-grant, and a randomized run against a cycle-level reference model.
module tb_ram_arbiter;

    localparam int N    = 19;
    localparam int HOLD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [7:0]   channel;
    logic [N-1:0] grant;
    logic         busy;
    logic         timeout;

    int tests = 0;
    int fails = 0;

    ram_arbiter #(.N_CH(N), .HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .channel(channel), .grant(grant), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         done;
        logic [7:0]   ech;
        logic         eto;
    } vec_t;

    vec_t tv[$];

    // reference model: 0 idle, 1 granted, 2 turnaround
    int   m_mode, m_owner, m_hold, m_last;
    logic m_to;

    task automatic add(input logic [N-1:0] r, input logic d, input logic [7:0] ch, input logic to);
        vec_t v;
        v.req = r; v.done = d; v.ech = ch; v.eto = to;
        tv.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [7:0] ech, input logic eto);
        logic [N-1:0] eg;
        logic         eb;
        eb = (ech != 8'hFF);
        eg = eb ? ({{(N-1){1'b0}}, 1'b1} << ech) : '0;
        tests++;
        if (channel !== ech || grant !== eg || busy !== eb || timeout !== eto) begin
            fails++;
            $display("FAIL %s: got ch=%0h grant=%0h busy=%0b to=%0b, want ch=%0h grant=%0h busy=%0b to=%0b",
                     nm, channel, grant, busy, timeout, ech, eg, eb, eto);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = 1'b0;
        step(); step();
        rst = 1'b0;
        m_mode = 0; m_owner = 0; m_hold = 0; m_last = N - 1; m_to = 1'b0;
    endtask

    // Advance the model over one clock edge with the given inputs
    task automatic model_step(input logic [N-1:0] r, input logic d);
        m_to = 1'b0;
        if (m_mode == 0) begin
            if (r != '0) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_last + k) % N;
                    if (r[idx]) begin
                        m_owner = idx; m_last = idx; m_hold = 0; m_mode = 1;
                        break;
                    end
                end
            end
        end else if (m_mode == 1) begin
            if (d || !r[m_owner] || m_hold == HOLD - 1) begin
                m_to   = (m_hold == HOLD - 1) && !d;
                m_mode = 2;
            end else begin
                m_hold++;
            end
        end else begin
            m_mode = 0;
        end
    endtask

    initial begin
        logic [N-1:0] p, r;
        logic         d;
        int           w;

        rst = 1'b1; req = '0; done = 1'b0;
        #3;
        check("reset_state", 8'hFF, 1'b0);
        step(); step();
        rst = 1'b0;

        // directed table, starting from reset (channel 0 favoured)
        p = '0; p[18] = 1'b1; p[2] = 1'b1;
        add(19'h00001, 1'b0, 8'd0,  1'b0);
        add(19'h00001, 1'b1, 8'hFF, 1'b0);
        add(19'h00000, 1'b0, 8'hFF, 1'b0);
        add(19'h00000, 1'b1, 8'hFF, 1'b0);   // stray done
        add(19'h00008, 1'b0, 8'd3,  1'b0);
        add(19'h00008, 1'b0, 8'd3,  1'b0);
        add(19'h00008, 1'b0, 8'd3,  1'b0);
        add(19'h00008, 1'b0, 8'd3,  1'b0);
        add(19'h00008, 1'b0, 8'hFF, 1'b1);   // hold limit -> timeout
        add(19'h00008, 1'b0, 8'hFF, 1'b0);
        add(19'h00008, 1'b0, 8'd3,  1'b0);   // re-grant to sole requester
        add(19'h00000, 1'b0, 8'hFF, 1'b0);   // owner drops request
        add(19'h00000, 1'b0, 8'hFF, 1'b0);
        add(p | 19'h00020, 1'b0, 8'd5,  1'b0);
        add(p | 19'h00020, 1'b0, 8'd5,  1'b0);
        add(p | 19'h00020, 1'b0, 8'd5,  1'b0);
        add(p | 19'h00020, 1'b0, 8'd5,  1'b0);
        add(p | 19'h00020, 1'b1, 8'hFF, 1'b0); // done with limit -> no timeout
        add(p, 1'b0, 8'hFF, 1'b0);
        add(p, 1'b0, 8'd18, 1'b0);
        add(p, 1'b1, 8'hFF, 1'b0);
        add(p, 1'b0, 8'hFF, 1'b0);
        add(p, 1'b0, 8'd2,  1'b0);             // wrap 18 -> 2
        add(p, 1'b1, 8'hFF, 1'b0);
        add(19'h00000, 1'b0, 8'hFF, 1'b0);
        foreach (tv[i]) begin
            req = tv[i].req; done = tv[i].done;
            step();
            check($sformatf("table[%0d]", i), tv[i].ech, tv[i].eto);
        end

        // full sweep with all channels requesting
        do_reset();
        req = '1;
        for (int g = 0; g < N + 2; g++) begin
            w = 0;
            while (!busy && w < 10) begin step(); w++; end
            check($sformatf("sweep[%0d]", g), 8'(g % N), 1'b0);
            done = 1'b1;
            step();
            done = 1'b0;
        end

        // async reset mid-grant of channel 7
        do_reset();
        req = '0; req[7] = 1'b1;
        step();
        check("pre_rst_grant7", 8'd7, 1'b0);
        step();
        #2 rst = 1'b1;
        #1 check("async_rst", 8'hFF, 1'b0);
        req[8] = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("post_rst_grant7", 8'd7, 1'b0);

        // randomized run against the model
        do_reset();
        r = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0)
                r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom);
            d = ($urandom_range(0, 5) == 0);
            req = r; done = d;
            model_step(r, d);
            step();
            check($sformatf("random[%0d]", c), (m_mode == 1) ? 8'(m_owner) : 8'hFF, m_to);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 19, number of requesting channels (range 2..255).
REQ-002 The block SHALL have parameter HOLD_MAX, default 255, maximum cycles one grant may last before forced release (range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port req, input, N_CH bits; bit i high means channel i requests the shared RAM.
REQ-006 The block SHALL have port done, input, 1 bit; a one-cycle pulse from the RAM side meaning the current transfer has finished.
REQ-007 The block SHALL have port channel, output, 8 bits, the granted channel index that drives the enable/data select mux; 8'hFF when no grant is active.
REQ-008 The block SHALL have port grant, output, N_CH bits, one-hot grant; all zero when idle.
REQ-009 The block SHALL have port busy, output, 1 bit; high whenever grant is nonzero.
REQ-010 The block SHALL have port timeout, output, 1 bit; a one-cycle pulse when a grant is force-released by HOLD_MAX.

Function
REQ-011 The block SHALL implement the states IDLE, GRANT and RELEASE.
REQ-012 In IDLE with any req bit high, the block SHALL select a winner, enter GRANT, and present grant/channel/busy registered on the next edge (1-cycle request-to-grant latency).
REQ-013 Winner selection SHALL be round-robin: search starts at index (last_granted+1) mod N_CH and picks the first requesting index upward, wrapping from N_CH-1 to 0.
REQ-014 last_granted SHALL reset to N_CH-1, so the first arbitration after reset favours channel 0.
REQ-015 In GRANT, channel and grant SHALL stay constant; requests from other channels SHALL NOT preempt.
REQ-016 In GRANT, the hold counter SHALL start at 0 on grant entry and increment each cycle, saturating at HOLD_MAX.
REQ-017 GRANT SHALL end on the first cycle in which any of these holds: done=1; req[granted]=0; hold counter = HOLD_MAX-1.
REQ-018 When GRANT ends, the block SHALL enter RELEASE with grant=0, channel=8'hFF and busy=0 on the next edge.
REQ-019 timeout SHALL pulse for exactly one cycle, coincident with the RELEASE cycle, only when HOLD_MAX ended the grant and done was low on that cycle.
REQ-020 If done and the HOLD_MAX condition coincide, the block SHALL treat the release as normal and SHALL NOT pulse timeout.
REQ-021 RELEASE SHALL last exactly one cycle (a bus turnaround) and then return to IDLE; arbitration for the next grant SHALL happen in IDLE, so back-to-back grants are separated by at least two non-granted cycles.
REQ-022 last_granted SHALL update to the granted index on GRANT entry.
REQ-023 A done pulse outside GRANT SHALL be ignored.
REQ-024 Request bits at indices >= N_CH SHALL be impossible by construction, and channel SHALL never carry a value in N_CH..254.
REQ-025 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-026 When rst is asserted, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, grant=0, channel=8'hFF, busy=0, timeout=0, hold counter=0 and last_granted=N_CH-1, including when rst arrives mid-GRANT.
REQ-027 On the first rising clk edge after rst deasserts, the block SHALL be able to issue a grant.

Verification
REQ-028 Reset, then req=19'h00001 -> grant=1, channel=0 and busy=1 one cycle later; done pulse -> RELEASE with channel=8'hFF, then IDLE.
REQ-029 req=all ones held with a done pulse after every grant -> channel sequence 0,1,...,18,0,1 with no repeats or skips.
REQ-030 Grant to channel 5 while req[18] and req[2] are pending -> next grants are 18 then 2, which checks wrap-around.
REQ-031 HOLD_MAX=4, req[3] held and no done -> grant lasts 4 cycles, a timeout pulse of exactly 1 cycle, then re-grant to 3 if it is the only requester.
REQ-032 rst asserted mid-GRANT of channel 7 -> outputs go to reset values with no clock edge; after release with req[7] and req[8] pending, channel 0 has priority order, so 7 is granted first.
REQ-033 req[granted] dropped mid-GRANT -> release on the next edge with no timeout pulse; done and the HOLD_MAX limit on the same cycle -> no timeout pulse.
